shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle shift controller for the 16-bit datapath. It accepts one shift request with an amount of 0..15, then iterates a one-bit-per-cycle shift stage until the amount is consumed. It returns the result with a one-cycle done pulse. It sits between the instruction decode/control FSM and the ALU result mux, and serves every shift instruction (logical and arithmetic, left and right).

Parameters:
WIDTH, 16, datapath width in bits
AMT_W, 4, width of the shift-amount field (maximum amount 2**AMT_W-1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only when the block can accept a request
src  input  WIDTH  operand to shift, latched on an accepted start
shiftDirection  input  1  1 = left, 0 = right; latched on an accepted start
shiftType  input  1  1 = logical, 0 = arithmetic; latched on an accepted start
shiftAmt  input  AMT_W  number of positions, 0..15; latched on an accepted start
busy  output  1  high while shifting is in progress
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  shifted value; held stable from done until the next accepted start

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- State machine states: IDLE, SHIFT, DONE.
- Reset (any state, including mid-shift): state=IDLE, busy=0, done=0, result=0, internal accumulator and counter cleared. No done pulse is produced for an aborted operation.
- Accept condition: start=1 while in IDLE or DONE. In SHIFT, start is ignored; the request is not queued, and all latched fields stay unchanged.
- On accept:
  - acc <= src; cnt <= shiftAmt; the direction and type are latched.
  - If shiftAmt==0: next state=DONE, and acc is passed through unchanged.
  - Otherwise: next state=SHIFT.
- SHIFT, once per cycle:
  - acc <= step(acc); cnt <= cnt-1.
  - When cnt==1 in this cycle, the next state is DONE.
  - busy=1 throughout SHIFT.
- DONE: done=1 for exactly this one cycle, busy=0, and result is valid.
  - Next state=SHIFT or DONE if start is accepted in this cycle (back-to-back). Otherwise next state=IDLE.
- result is a register loaded from acc on the transition into DONE. It holds in IDLE.
- Latency: with start accepted in cycle 0 and amount N, done is high in cycle N+1. N=0 gives done in cycle 1; N=15 gives done in cycle 16.
- Step function (one position per cycle):
  - Right logical: MSB filled with 0.
  - Right arithmetic: MSB filled with the latched sign bit, i.e. the MSB of acc.
  - Left logical and left arithmetic are identical: LSB filled with 0.
- Amount range: the full range 0..15 is legal in both directions. There is no saturation and no wrap. After 15 right-logical steps, only the original MSB remains, in bit 0.
- Inputs src, shiftDirection, shiftType and shiftAmt may change freely while busy. Only the values present at the accepted start are used.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package `shift_pkg` holds:
  - Localparams for the state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Direction constants: DIR_LEFT=1, DIR_RIGHT=0.
  - Type constants: TYPE_LOGICAL=1, TYPE_ARITH=0.
- One natural sub-module: `one_bit_shift`. It is a purely combinational single-position shifter with parameter WIDTH and ports in, dir, type, out. It is instantiated once on the accumulator path; the FSM, counter and result register stay in `shift_sequencer`.

Test Plan:
1. Right logical: src=16'h8001, dir=0, type=1, amt=3, start in cycle 0 -> busy high in cycles 1-3; done=1 in cycle 4 only; result=16'h1000.
2. Right arithmetic: src=16'h8000, dir=0, type=0, amt=15 -> done in cycle 16, result=16'hFFFF. Repeat with src=16'h4000 -> result=16'h0000.
3. Left at maximum: src=16'h0001, dir=1, amt=15, type=0 then type=1 -> result=16'h8000 in both cases, done in cycle 16.
4. Zero amount: src=16'hA5A5, amt=0 -> done in cycle 1, result=16'hA5A5, busy never asserted.
5. Start during busy: start amt=5 on src=16'h00F0 right logical, then pulse start with src=16'hFFFF in cycle 2 -> ignored; result=16'h0007 with done in cycle 6. Then a start in the done cycle with amt=1, left -> result=16'h000E one done pulse later, with no intervening IDLE.
6. Reset mid-operation: start amt=10, assert reset in cycle 4 -> cycle 5 shows busy=0, done=0, result=0. No done pulse follows, and a new start is accepted normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift controller: FSM state
// encoding plus direction and type constants used by the datapath.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT     = 1'b1;
    localparam logic DIR_RIGHT    = 1'b0;
    localparam logic TYPE_LOGICAL = 1'b1;
    localparam logic TYPE_ARITH   = 1'b0;

endpackage

// File: rtl/one_bit_shift.sv
// Purely combinational single-position shifter used once per cycle on the
// shift_sequencer accumulator path.
module one_bit_shift
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    input  logic             dir,
    input  logic             shType,
    output logic [WIDTH-1:0] out
);

    // Left shifts ignore the type; right arithmetic replicates the current MSB.
    always_comb begin
        out = in;
        if (dir == DIR_LEFT) begin
            out = {in[WIDTH-2:0], 1'b0};
        end else if (shType == TYPE_LOGICAL) begin
            out = {1'b0, in[WIDTH-1:1]};
        end else begin
            out = {in[WIDTH-1], in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts one request, shifts the accumulator
// one position per cycle, then presents the result with a one-cycle done pulse.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic             shiftDirection,
    input  logic             shiftType,
    input  logic [AMT_W-1:0] shiftAmt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             type_q, type_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] stepOut;
    logic             accept;

    one_bit_shift #(.WIDTH(WIDTH)) u_step (
        .in     (acc_q),
        .dir    (dir_q),
        .shType (type_q),
        .out    (stepOut)
    );

    // Requests are only taken when not mid-shift; DONE allows back-to-back.
    assign accept = start && (state_q != SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            type_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            type_q   <= type_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = (shiftAmt == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result is captured on entry to DONE: straight from src for a zero
    // amount, otherwise from the final step of the shifter.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        type_d   = type_q;
        result_d = result_q;
        if (accept) begin
            acc_d  = src;
            cnt_d  = shiftAmt;
            dir_d  = shiftDirection;
            type_d = shiftType;
        end else if (state_q == SHIFT) begin
            acc_d = stepOut;
            cnt_d = cnt_q - AMT_W'(1);
        end
        if (state_d == DONE) begin
            result_d = accept ? src : stepOut;
        end
    end

    always_comb begin
        busy   = (state_q == SHIFT);
        done   = (state_q == DONE);
        result = result_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results from
// an arithmetic reference model, a negedge monitor pops and compares.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic        shiftDirection;
    logic        shiftType;
    logic [3:0]  shiftAmt;
    logic        busy;
    logic        done;
    logic [15:0] result;

    typedef struct {
        logic [15:0] res;
        int          issue;
        int          doneCycle;
    } exp_t;

    exp_t        sb[$];
    int          cycleCount = 0;
    int          lastDoneCycle = 0;
    logic [15:0] heldResult = '0;
    int          checks = 0;
    int          errors = 0;

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src            (src),
        .shiftDirection (shiftDirection),
        .shiftType      (shiftType),
        .shiftAmt       (shiftAmt),
        .busy           (busy),
        .done           (done),
        .result         (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    function automatic logic [15:0] refShift(input logic [15:0] s, input logic d,
                                             input logic t, input logic [3:0] a);
        if (d) return s << a;
        if (t) return s >> a;
        return 16'($signed(s) >>> a);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycleCount, actual, required);
        end
    endtask

    // Called #1 after a rising edge; drives a one-cycle start pulse.
    task automatic applyStimulus(input logic [15:0] s, input logic d, input logic t,
                                 input logic [3:0] a);
        exp_t e;
        start          = 1'b1;
        src            = s;
        shiftDirection = d;
        shiftType      = t;
        shiftAmt       = a;
        if (cycleCount >= lastDoneCycle) begin
            e.res       = refShift(s, d, t, a);
            e.issue     = cycleCount;
            e.doneCycle = cycleCount + int'(a) + 1;
            sb.push_back(e);
            lastDoneCycle = e.doneCycle;
        end
        @(posedge clk); #1;
        start          = 1'b0;
        src            = 16'($urandom);
        shiftDirection = 1'($urandom);
        shiftType      = 1'($urandom);
        shiftAmt       = 4'($urandom);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitUntil(input int target);
        while (cycleCount < target) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (sb.size() > 0 && cycleCount == sb[0].doneCycle) begin
                checkOutput("done_pulse", 16'(done), 16'd1);
                checkOutput("busy_in_done", 16'(busy), 16'd0);
                checkOutput("result", result, sb[0].res);
                heldResult = sb[0].res;
                void'(sb.pop_front());
            end else begin
                checkOutput("no_done", 16'(done), 16'd0);
                if (sb.size() > 0) begin
                    checkOutput("busy", 16'(busy),
                                16'(cycleCount > sb[0].issue && cycleCount < sb[0].doneCycle));
                end else begin
                    checkOutput("busy_idle", 16'(busy), 16'd0);
                    checkOutput("result_hold", result, heldResult);
                end
            end
        end
    end

    initial begin
        int c0;
        reset          = 1'b1;
        start          = 1'b0;
        src            = '0;
        shiftDirection = 1'b0;
        shiftType      = 1'b0;
        shiftAmt       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        lastDoneCycle = cycleCount;
        idleCycles(2);

        applyStimulus(16'h8001, 1'b0, 1'b1, 4'd3);
        waitUntil(lastDoneCycle + 1);
        applyStimulus(16'h8000, 1'b0, 1'b0, 4'd15);
        waitUntil(lastDoneCycle + 1);
        applyStimulus(16'h4000, 1'b0, 1'b0, 4'd15);
        waitUntil(lastDoneCycle + 1);
        applyStimulus(16'h0001, 1'b1, 1'b0, 4'd15);
        waitUntil(lastDoneCycle + 1);
        applyStimulus(16'h0001, 1'b1, 1'b1, 4'd15);
        waitUntil(lastDoneCycle + 1);
        applyStimulus(16'hA5A5, 1'b0, 1'b1, 4'd0);
        idleCycles(2);

        // Start while busy is dropped; start in the done cycle chains directly.
        c0 = cycleCount;
        applyStimulus(16'h00F0, 1'b0, 1'b1, 4'd5);
        idleCycles(1);
        applyStimulus(16'hFFFF, 1'b1, 1'b0, 4'd2);
        waitUntil(c0 + 6);
        applyStimulus(16'h0007, 1'b1, 1'b1, 4'd1);
        waitUntil(lastDoneCycle + 2);

        c0 = cycleCount;
        applyStimulus(16'h1234, 1'b1, 1'b1, 4'd10);
        waitUntil(c0 + 4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        heldResult = '0;
        lastDoneCycle = cycleCount;
        idleCycles(12);
        applyStimulus(16'hC3C3, 1'b0, 1'b0, 4'd4);
        waitUntil(lastDoneCycle + 1);

        repeat (80) begin
            applyStimulus(16'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            idleCycles($urandom_range(0, 4));
        end

        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        idleCycles(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
